// File: rtl/bgr_startup_seq_if.sv
// Control/status bundle between the user-project logic and the bandgap start-up sequencer.
// enable is a level request; there is no valid/ready handshake, and status outputs are plain registered levels.
interface bgr_startup_seq_if;
  logic       enable;
  logic       vbg_ok;
  logic       bgr_en;
  logic       porst;
  logic       ready;
  logic       fault;
  logic [1:0] retries;
  logic [2:0] state;

  modport master (
    output enable,
    output vbg_ok,
    input  bgr_en,
    input  porst,
    input  ready,
    input  fault,
    input  retries,
    input  state
  );

  modport slave (
    input  enable,
    input  vbg_ok,
    output bgr_en,
    output porst,
    output ready,
    output fault,
    output retries,
    output state
  );
endinterface

// File: rtl/bgr_startup_seq.sv
// Power-up sequencer for the bandgap reference: porst pulse, settle wait,
// qualification of the synchronized vbg_ok comparator, and bounded retries.
module bgr_startup_seq #(
  parameter int unsigned POR_CYCLES     = 8,
  parameter int unsigned SETTLE_CYCLES  = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned QUAL_CYCLES    = 4,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input logic              clk,
  input logic              resetb,
  bgr_startup_seq_if.slave bgr
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PULSE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_READY  = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  localparam logic [15:0] POR_LAST    = 16'(POR_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]  QUAL_CNT    = 4'(QUAL_CYCLES);
  localparam logic [1:0]  RETRY_MAX   = 2'(MAX_RETRIES);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [15:0] r_phase;
  logic [3:0]  r_qcnt;
  logic [1:0]  r_retries;
  logic [1:0]  w_retries_nxt;
  logic        r_sync0;
  logic        r_ok_s;
  logic        r_bgr_en;
  logic        r_porst;
  logic        r_ready;
  logic        r_fault;
  logic        w_fail;
  logic        w_qual_hit;
  logic        w_entry;
  logic [3:0]  w_qcnt_inc;

  // vbg_ok comes straight from an analog comparator
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_sync0 <= 1'b0;
      r_ok_s  <= 1'b0;
    end else begin
      r_sync0 <= bgr.vbg_ok;
      r_ok_s  <= r_sync0;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_retries_nxt = r_retries;
    w_fail        = 1'b0;
    w_qual_hit    = (r_qcnt == QUAL_CNT);
    if (!bgr.enable) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt   = ST_PULSE;
          w_retries_nxt = 2'd0;
        end
        ST_PULSE: begin
          if (r_phase == POR_LAST) w_state_nxt = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_phase == SETTLE_LAST) w_state_nxt = ST_CHECK;
        end
        ST_CHECK: begin
          // qualification wins a same-cycle tie with the timeout
          if (w_qual_hit) w_state_nxt = ST_READY;
          else if (r_phase == TIMEOUT_CNT) w_fail = 1'b1;
        end
        ST_READY: begin
          if (w_qual_hit) w_fail = 1'b1;
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_OFF;
        end
      endcase
      if (w_fail) begin
        if (r_retries < RETRY_MAX) begin
          w_retries_nxt = r_retries + 2'd1;
          w_state_nxt   = ST_PULSE;
        end else begin
          w_state_nxt   = ST_FAULT;
        end
      end
    end
  end

  assign w_entry    = (w_state_nxt != r_state);
  assign w_qcnt_inc = (r_qcnt == 4'hF) ? r_qcnt : r_qcnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_state   <= ST_OFF;
      r_retries <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_retries <= w_retries_nxt;
    end
  end

  // phase and qualification counters restart on every state entry
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_phase <= 16'd0;
      r_qcnt  <= 4'd0;
    end else if (w_entry) begin
      r_phase <= 16'd0;
      r_qcnt  <= 4'd0;
    end else begin
      if (r_phase != 16'hFFFF) r_phase <= r_phase + 16'd1;
      case (r_state)
        ST_CHECK: r_qcnt <= r_ok_s ? w_qcnt_inc : 4'd0;
        ST_READY: r_qcnt <= r_ok_s ? 4'd0 : w_qcnt_inc;
        default:  r_qcnt <= 4'd0;
      endcase
    end
  end

  // outputs decode the next state so they move on the same edge as r_state
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_bgr_en <= 1'b0;
      r_porst  <= 1'b0;
      r_ready  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_bgr_en <= (w_state_nxt == ST_PULSE) || (w_state_nxt == ST_SETTLE) ||
                  (w_state_nxt == ST_CHECK) || (w_state_nxt == ST_READY);
      r_porst  <= (w_state_nxt == ST_PULSE);
      r_ready  <= (w_state_nxt == ST_READY);
      r_fault  <= (w_state_nxt == ST_FAULT);
    end
  end

  assign bgr.bgr_en  = r_bgr_en;
  assign bgr.porst   = r_porst;
  assign bgr.ready   = r_ready;
  assign bgr.fault   = r_fault;
  assign bgr.retries = r_retries;
  assign bgr.state   = r_state;

endmodule

// File: tb/tb_bgr_startup_seq.sv
// Directed bench for bgr_startup_seq: nominal start, retry, exhaustion, loss in READY,
// aborts and the qualification/timeout tie, all against hand-derived edge counts.
module tb_bgr_startup_seq;
  localparam int POR     = 4;
  localparam int SETTLE  = 10;
  localparam int TIMEOUT = 20;
  localparam int QUAL    = 4;
  localparam int RETRIES = 2;

  logic       clk = 1'b0;
  logic       resetb;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] exp_q[$];
  logic [2:0] e;
  int         pulses;
  logic       prev_porst;

  bgr_startup_seq_if bgr();

  bgr_startup_seq #(
    .POR_CYCLES    (POR),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .QUAL_CYCLES   (QUAL),
    .MAX_RETRIES   (RETRIES)
  ) dut (
    .clk   (clk),
    .resetb(resetb),
    .bgr   (bgr)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: advance n edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard model: outputs are a pure decode of the state
  task automatic check_state(input string tag, input logic [2:0] exp_st);
    check({tag, ".state"},  16'(bgr.state),  16'(exp_st));
    check({tag, ".bgr_en"}, 16'(bgr.bgr_en), 16'(exp_st >= 3'd1 && exp_st <= 3'd4));
    check({tag, ".porst"},  16'(bgr.porst),  16'(exp_st == 3'd1));
    check({tag, ".ready"},  16'(bgr.ready),  16'(exp_st == 3'd4));
    check({tag, ".fault"},  16'(bgr.fault),  16'(exp_st == 3'd5));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    resetb     = 1'b0;
    bgr.enable = 1'b0;
    bgr.vbg_ok = 1'b1;
    step(3);
    check_state("reset", 3'd0);
    check("reset.retries", 16'(bgr.retries), 16'd0);
    resetb = 1'b1;
    step(3);

    // nominal start: enable seen at E1, PULSE E1..E4, SETTLE E5..E14, CHECK E15..E19, READY E20
    bgr.enable = 1'b1;
    for (int i = 0; i < POR; i++) exp_q.push_back(3'd1);
    for (int i = 0; i < SETTLE; i++) exp_q.push_back(3'd2);
    for (int i = 0; i < QUAL + 1; i++) exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    while (exp_q.size() > 0) begin
      step(1);
      e = exp_q.pop_front();
      check_state("nominal", e);
    end
    check("nominal.retries", 16'(bgr.retries), 16'd0);

    // 2-cycle dropout in READY is filtered
    bgr.vbg_ok = 1'b0;
    step(2);
    bgr.vbg_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_state("short_drop", 3'd4);
    end

    // 6-cycle dropout: fourth bad sample at F6, retry pulse at F7
    bgr.vbg_ok = 1'b0;
    step(6);
    check_state("long_drop.hold", 3'd4);
    step(1);
    check_state("long_drop.retry", 3'd1);
    check("long_drop.retries", 16'(bgr.retries), 16'd1);
    bgr.vbg_ok = 1'b1;
    step(POR + SETTLE + QUAL + 1);
    check_state("long_drop.reready", 3'd4);
    check("long_drop.retries_hold", 16'(bgr.retries), 16'd1);
    bgr.enable = 1'b0;
    step(1);
    check_state("disable", 3'd0);

    // retry then success: CHECK E15..E35, timeout at E36
    bgr.vbg_ok = 1'b0;
    step(3);
    bgr.enable = 1'b1;
    step(35);
    check_state("retry.check_last", 3'd3);
    step(1);
    check_state("retry.pulse", 3'd1);
    check("retry.retries", 16'(bgr.retries), 16'd1);
    bgr.vbg_ok = 1'b1;
    step(18);
    check_state("retry.check2", 3'd3);
    step(1);
    check_state("retry.ready", 3'd4);
    check("retry.retries2", 16'(bgr.retries), 16'd1);
    bgr.enable = 1'b0;
    step(1);
    check_state("retry.off", 3'd0);

    // exhaustion: pulses at E1, E36, E71; FAULT at E106
    bgr.vbg_ok = 1'b0;
    step(3);
    bgr.enable = 1'b1;
    pulses     = 0;
    prev_porst = 1'b0;
    for (int i = 0; i < 105; i++) begin
      step(1);
      if (bgr.porst && !prev_porst) pulses++;
      prev_porst = bgr.porst;
    end
    check("exhaust.pulses", 16'(pulses), 16'd3);
    check_state("exhaust.last_check", 3'd3);
    step(1);
    check_state("exhaust.fault", 3'd5);
    check("exhaust.retries", 16'(bgr.retries), 16'd2);
    step(5);
    check_state("exhaust.sticky", 3'd5);
    bgr.enable = 1'b0;
    step(1);
    check_state("exhaust.off", 3'd0);
    bgr.enable = 1'b1;
    step(1);
    check_state("exhaust.restart", 3'd1);
    check("exhaust.retries_clr", 16'(bgr.retries), 16'd0);

    // abort mid-PULSE, then 1->0->1 passes through OFF for one cycle
    step(1);
    bgr.enable = 1'b0;
    step(1);
    check_state("abort.pulse", 3'd0);
    bgr.enable = 1'b1;
    step(1);
    check_state("abort.toggle", 3'd1);
    step(5);
    check_state("abort.settle", 3'd2);
    resetb = 1'b0;
    step(1);
    check_state("abort.reset", 3'd0);
    check("abort.retries", 16'(bgr.retries), 16'd0);
    bgr.enable = 1'b0;
    bgr.vbg_ok = 1'b0;
    resetb     = 1'b1;
    step(3);

    // tie: ok_s good at E32..E35, qcnt and phase both hit at E36
    bgr.enable = 1'b1;
    step(29);
    bgr.vbg_ok = 1'b1;
    step(6);
    check_state("tie.check", 3'd3);
    step(1);
    check_state("tie.ready", 3'd4);
    check("tie.retries", 16'(bgr.retries), 16'd0);
    step(3);
    check_state("tie.stay", 3'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
